// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a small first-word-fall-through FIFO.
// Overrun and framing errors are reported as single-cycle pulses aligned with the FIFO update.
module uart_rx_fifo #(
  parameter int DVSR    = 52,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW    = $clog2(DBIT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                rx_meta_q, rx_s_q;
  logic [CW-1:0]       cnt_q;
  logic                s_tick;
  state_t              state_q, state_d;
  logic [3:0]          s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [7:0]          b_q, b_d;
  logic                stop_done, wr_en, ovr_d, ferr_d, pop;
  logic                overrun_q, frame_err_q;
  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_AW:0]    wptr_q, rptr_q;

  // Synchroniser presets high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= s_tick ? '0 : cnt_q + 1'b1;
    end
  end

  assign s_tick = (cnt_q == CW'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
    end
  end

  always_ff @(posedge clk) begin
    b_q <= b_d;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[7:1]};
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) state_d = IDLE;
          else                        s_d = s_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the stop-sample cycle frees the slot, so a full FIFO still accepts the byte
  always_comb begin
    stop_done = (state_q == STOP) && s_tick && (s_q == 4'(SB_TICK - 1));
    wr_en     = stop_done && rx_s_q && (!rx_full || pop);
    ovr_d     = stop_done && rx_s_q && rx_full && !pop;
    ferr_d    = stop_done && !rx_s_q;
  end

  assign rx_empty = (wptr_q == rptr_q);
  assign rx_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop      = rd && !rx_empty;
  assign rx_data  = mem_q[rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      overrun_q   <= ovr_d;
      frame_err_q <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[FIFO_AW-1:0]] <= b_q;
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
